// File: rtl/display_scheduler.sv
// display_scheduler: arbitrates result/entry display requests onto the 7-segment serializer and refreshes the held frame.
// Optional feature: define DISPLAY_SCHED_LZ_BLANK_EN to blank leading zero digits when a frame is loaded.
module display_scheduler #(
  parameter int unsigned REFRESH_CYCLES = 4096,
  parameter int unsigned START_TIMEOUT  = 8,
  parameter logic [3:0]  BLANK_DIGIT    = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_result,
  input  logic [15:0] result_bcd,
  output logic        ack_result,
  input  logic        req_entry,
  input  logic [15:0] entry_bcd,
  output logic        ack_entry,
  input  logic        ser_busy,
  output logic        ser_enable,
  output logic [15:0] ser_bcd,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT_DONE} state_e;

  localparam int unsigned RCW = $clog2(REFRESH_CYCLES);
  localparam int unsigned TCW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [RCW-1:0] REFRESH_LAST = RCW'(REFRESH_CYCLES - 1);
  localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(START_TIMEOUT - 1);
  localparam logic [15:0]    BLANK_WORD   = {4{BLANK_DIGIT}};

  state_e          state_q, state_d;
  logic [15:0]     held_q, held_d;
  logic [15:0]     ser_bcd_q, ser_bcd_d;
  logic            ser_enable_q, ser_enable_d;
  logic            timeout_err_q, timeout_err_d;
  logic [RCW-1:0]  refresh_cnt_q, refresh_cnt_d;
  logic [TCW-1:0]  start_cnt_q, start_cnt_d;

  function automatic logic [15:0] display_word(input logic [15:0] word);
`ifdef DISPLAY_SCHED_LZ_BLANK_EN
    logic [15:0] shown;
    logic        leading;
    shown   = word;
    leading = 1'b1;
    // The units digit [3:0] is always shown, so a zero value renders as a single 0.
    for (int i = 3; i >= 1; i--) begin
      if (leading && (word[i*4 +: 4] == 4'h0)) shown[i*4 +: 4] = BLANK_DIGIT;
      else leading = 1'b0;
    end
    return shown;
`else
    return word;
`endif
  endfunction

  // Acks answer in the very cycle the request is sampled in IDLE, so they decode state and request directly.
  assign ack_result = rst && (state_q == IDLE) && req_result;
  assign ack_entry  = rst && (state_q == IDLE) && !req_result && req_entry;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
    state_d       = state_q;
    held_d        = held_q;
    ser_bcd_d     = ser_bcd_q;
    ser_enable_d  = ser_enable_q;
    timeout_err_d = timeout_err_q;
    refresh_cnt_d = refresh_cnt_q;
    start_cnt_d   = start_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_result) begin
          held_d  = result_bcd;
          state_d = LOAD;
        end else if (req_entry) begin
          held_d  = entry_bcd;
          state_d = LOAD;
        end else if (refresh_cnt_q == REFRESH_LAST) begin
          state_d = LOAD;
        end else begin
          refresh_cnt_d = refresh_cnt_q + 1'b1;
        end
      end
      LOAD: begin
        ser_bcd_d     = display_word(held_q);
        refresh_cnt_d = '0;
        start_cnt_d   = '0;
        ser_enable_d  = 1'b1;
        state_d       = START;
      end
      START: begin
        if (ser_busy) begin
          ser_enable_d = 1'b0;
          state_d      = WAIT_DONE;
        end else if (start_cnt_q == TIMEOUT_LAST) begin
          ser_enable_d  = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          start_cnt_d = start_cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!ser_busy) begin
          timeout_err_d = 1'b0;
          refresh_cnt_d = '0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      held_q        <= BLANK_WORD;
      ser_bcd_q     <= BLANK_WORD;
      ser_enable_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      refresh_cnt_q <= '0;
      start_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values regardless of statement order.
      state_q       <= state_d;
      held_q        <= held_d;
      ser_bcd_q     <= ser_bcd_d;
      ser_enable_q  <= ser_enable_d;
      timeout_err_q <= timeout_err_d;
      refresh_cnt_q <= refresh_cnt_d;
      start_cnt_q   <= start_cnt_d;
    end
  end

  assign ser_enable  = ser_enable_q;
  assign ser_bcd     = ser_bcd_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed bench for display_scheduler with a small serializer responder model.
module tb_display_scheduler;

  localparam int unsigned REFRESH  = 16;
  localparam int unsigned TIMEOUT  = 8;
  localparam int          BUSY_LEN = 20;
`ifdef DISPLAY_SCHED_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_result, req_entry;
  logic [15:0] result_bcd, entry_bcd;
  logic        ack_result, ack_entry;
  logic        ser_busy, ser_enable, busy, timeout_err;
  logic [15:0] ser_bcd;

  int pass_cnt  = 0;
  int check_cnt = 0;
  bit ser_auto  = 1'b1;
  int busy_left;

  always #5 clk = ~clk;

  display_scheduler #(
    .REFRESH_CYCLES(REFRESH),
    .START_TIMEOUT (TIMEOUT),
    .BLANK_DIGIT   (4'hF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_result (req_result),
    .result_bcd (result_bcd),
    .ack_result (ack_result),
    .req_entry  (req_entry),
    .entry_bcd  (entry_bcd),
    .ack_entry  (ack_entry),
    .ser_busy   (ser_busy),
    .ser_enable (ser_enable),
    .ser_bcd    (ser_bcd),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  // Serializer stand-in: sees enable on an edge, then holds busy for BUSY_LEN cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ser_busy  <= 1'b0;
      busy_left <= 0;
    end else if (!ser_auto) begin
      ser_busy  <= 1'b0;
      busy_left <= 0;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
      if (busy_left == 1) ser_busy <= 1'b0;
    end else if (ser_enable && !ser_busy) begin
      ser_busy  <= 1'b1;
      busy_left <= BUSY_LEN;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Counts rising clock edges from the current negedge until ser_enable is seen high.
  task automatic wait_enable(input int max_cycles, output int n);
    n = 0;
    while (!ser_enable && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 0);
  endtask

  // Raise one request in IDLE at a negedge, hold it across the capturing edge, then drop it.
  task automatic request(input bit is_result, input logic [15:0] word,
                         input logic [15:0] exp_bcd, input string tag);
    if (is_result) begin
      req_result = 1'b1;
      result_bcd = word;
    end else begin
      req_entry = 1'b1;
      entry_bcd = word;
    end
    #1;
    check({tag, "_ack"}, is_result ? ack_result : ack_entry, 1);
    check({tag, "_ack_other"}, is_result ? ack_entry : ack_result, 0);
    @(negedge clk);
    check({tag, "_ack_pulse"}, is_result ? ack_result : ack_entry, 0);
    check({tag, "_en_load"}, ser_enable, 0);
    req_result = 1'b0;
    req_entry  = 1'b0;
    @(negedge clk);
    check({tag, "_en_start"}, ser_enable, 1);
    check({tag, "_bcd"}, ser_bcd, exp_bcd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int early;
    int changes;
    req_result = 1'b0;
    req_entry  = 1'b0;
    result_bcd = 16'h0;
    entry_bcd  = 16'h0;
    rst        = 1'b1;
    #1 rst     = 1'b0;
    #11;

    // Reset state
    check("rst_enable", ser_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_bcd", ser_bcd, 16'hFFFF);
    check("rst_ack_result", ack_result, 0);
    check("rst_ack_entry", ack_entry, 0);

    // Refresh-only frames: counter 0..R-1 in IDLE, LOAD, then START -> enable after R+1 edges
    @(negedge clk);
    rst = 1'b1;
    wait_enable(200, n);
    check("t1_first_frame_cycles", n, REFRESH + 1);
    check("t1_first_bcd", ser_bcd, 16'hFFFF);
    @(negedge clk);
    check("t1_busy_seen_en_high", ser_enable, 1);
    @(negedge clk);
    check("t1_en_dropped", ser_enable, 0);
    check("t1_wait_done_busy", busy, 1);
    n = 0;
    while (ser_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    // busy low seen in WAIT_DONE, one edge to IDLE, R idle cycles, LOAD -> R+2 edges
    wait_enable(200, n);
    check("t1_refresh_gap", n, REFRESH + 2);
    wait_idle("t1_idle");

    // Single entry request
    request(1'b0, 16'h0042, LZ ? 16'hFF42 : 16'h0042, "t2");
    wait_idle("t2_idle");

    // Simultaneous requests: result first, entry only after the frame completes
    req_result = 1'b1;
    result_bcd = 16'h1234;
    req_entry  = 1'b1;
    entry_bcd  = 16'h0007;
    #1;
    check("t3_ack_result", ack_result, 1);
    check("t3_ack_entry_blocked", ack_entry, 0);
    @(negedge clk);
    req_result = 1'b0;
    check("t3_ack_entry_load", ack_entry, 0);
    @(negedge clk);
    check("t3_en_start", ser_enable, 1);
    check("t3_bcd_result", ser_bcd, 16'h1234);
    n       = 0;
    early   = 0;
    changes = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
      if (busy && ack_entry) early++;
      if (ser_busy && ser_bcd != 16'h1234) changes++;
    end
    check("t3_no_early_entry_ack", early, 0);
    check("t3_bcd_stable_busy", changes, 0);
    check("t3_ack_entry_idle", ack_entry, 1);
    check("t3_bcd_held_idle", ser_bcd, 16'h1234);
    @(posedge clk);
    #1 req_entry = 1'b0;
    @(negedge clk);
    check("t3_entry_en_load", ser_enable, 0);
    @(negedge clk);
    check("t3_entry_en_start", ser_enable, 1);
    check("t3_entry_bcd", ser_bcd, LZ ? 16'hFFF7 : 16'h0007);
    wait_idle("t3_idle");

    // Start timeout with the serializer never answering
    ser_auto = 1'b0;
    request(1'b0, 16'h0005, LZ ? 16'hFFF5 : 16'h0005, "t4");
    n = 0;
    while (ser_enable && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_enable_cycles", n, TIMEOUT);
    check("t4_timeout_err", timeout_err, 1);
    check("t4_back_idle", busy, 0);
    ser_auto = 1'b1;
    wait_enable(200, n);
    check("t4_refresh_cycles", n, REFRESH + 1);
    check("t4_refresh_bcd", ser_bcd, LZ ? 16'hFFF5 : 16'h0005);
    check("t4_err_sticky", timeout_err, 1);
    wait_idle("t4_idle");
    check("t4_err_cleared", timeout_err, 0);

    // Asynchronous reset during WAIT_DONE with timeout_err set
    ser_auto = 1'b0;
    request(1'b1, 16'h2468, 16'h2468, "t5a");
    n = 0;
    while (ser_enable && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_timeout_err", timeout_err, 1);
    ser_auto = 1'b1;
    request(1'b0, 16'h1357, 16'h1357, "t5b");
    @(negedge clk);
    check("t5_en_with_busy", ser_enable, 1);
    @(negedge clk);
    check("t5_wait_en", ser_enable, 0);
    check("t5_wait_busy", busy, 1);
    check("t5_wait_err", timeout_err, 1);
    #2 rst = 1'b0;
    #1;
    check("t5_async_busy", busy, 0);
    check("t5_async_enable", ser_enable, 0);
    check("t5_async_err", timeout_err, 0);
    check("t5_async_bcd", ser_bcd, 16'hFFFF);
    @(negedge clk);
    rst = 1'b1;
    wait_enable(200, n);
    check("t5_post_rst_cycles", n, REFRESH + 1);
    check("t5_post_rst_bcd", ser_bcd, 16'hFFFF);
    wait_idle("t5_idle");

    // Leading-zero handling on loaded frames
    request(1'b1, 16'h0000, LZ ? 16'hFFF0 : 16'h0000, "t6a");
    wait_idle("t6a_idle");
    request(1'b1, 16'h1000, 16'h1000, "t6b");
    wait_idle("t6b_idle");
    request(1'b0, 16'h0100, LZ ? 16'hF100 : 16'h0100, "t6c");
    wait_idle("t6c_idle");
    request(1'b0, 16'h0010, LZ ? 16'hFF10 : 16'h0010, "t6d");
    wait_idle("t6d_idle");

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
